frankie_cycle_sequencer: RTL and testbench
==========================================

Name: frankie_cycle_sequencer

Overview:
- Multicycle sequencer for the "Frankie" accumulator CPU. Steps each instruction through fetch, decode, optional data-memory access and commit.
- Owns the single shared memory port, granting it to instruction fetch or data access.
- Holds the instruction register that feeds OPCODE/flagbit to the control unit.
- Emits one-cycle commit and PC-increment strobes that gate all register, PC and SP writes.

Parameters:
- WAIT_LIMIT, 15, max cycles a memory request may wait for MemReady before FAULT; range 1..255.
- HALT_OP, 5'b11111, opcode that stops the sequencer.
- IR_WIDTH, 16, instruction width; OPCODE = IR[IR_WIDTH-1 -: 5], flagbit = IR[IR_WIDTH-6].

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- Run  input  1  level; 1 = keep executing.
- Instr  input  IR_WIDTH  read data from memory port.
- MemReady  input  1  memory completes the current request this cycle.
- MemAccess  input  1  from control unit: decoded instruction needs a data-memory cycle.
- MemWriteCU  input  1  from control unit: data access is a write.
- JumpCU  input  1  from control unit: PCWrite asserted (jump/branch).
- OPCODE  output  5  registered opcode field of IR.
- flagbit  output  1  registered flag bit of IR.
- IRWrite  output  1  pulse when IR captures Instr.
- MemReq  output  1  memory request valid.
- FetchSel  output  1  address mux: 1 = PC, 0 = data address.
- MemWE  output  1  memory write enable; only valid with MemReq.
- WriteEn  output  1  commit strobe; gates all architectural writes.
- PCInc  output  1  PC <= PC+1 strobe.
- Halted  output  1  sequencer stopped on HALT_OP.
- Fault  output  1  sticky memory timeout.
- InstrCount  output  16  committed instruction counter.
- State  output  3  current state, for debug.

Behaviour:
- Reset (async, immediate): state IDLE; IR=0; OPCODE=0; flagbit=0; wait counter=0; InstrCount=0; Halted=0; Fault=0. All strobes (IRWrite, MemReq, FetchSel, MemWE, WriteEn, PCInc) are 0. Reset mid-instruction abandons it; nothing commits.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMACC=3, COMMIT=4, FAULT=5. Codes 6 and 7 are illegal and return to IDLE on the next clock.
- MemReq, FetchSel, MemWE, WriteEn and PCInc are Moore outputs decoded from the state register. IRWrite is Mealy: FETCH & MemReady.
- IDLE: all strobes 0. If Run=1, go to FETCH and clear Halted; otherwise stay.
- FETCH: MemReq=1, FetchSel=1, MemWE=0.
  - On MemReady: IR<=Instr, IRWrite=1 that cycle, counter cleared, go to DECODE.
  - Otherwise the counter increments. When the counter reaches WAIT_LIMIT with MemReady still 0, go to FAULT.
- DECODE: one cycle, no strobes; OPCODE/flagbit stable from IR.
  - If OPCODE==HALT_OP: go to IDLE and set Halted=1. No commit, no PCInc, InstrCount unchanged.
  - Else if MemAccess=1: go to MEMACC.
  - Else: go to COMMIT.
- MEMACC: MemReq=1, FetchSel=0, MemWE=MemWriteCU.
  - On MemReady: go to COMMIT and clear the counter.
  - Timeout behaves as in FETCH, going to FAULT.
- COMMIT: WriteEn=1 for exactly one cycle. PCInc=1 iff JumpCU=0 (jump and increment are mutually exclusive). InstrCount+1, wrapping 16'hFFFF -> 0.
  - Next state: FETCH if Run=1, else IDLE.
- Run deasserted mid-instruction: the current instruction completes; the sequencer stops at COMMIT.
- FAULT: Fault=1, all strobes 0. Stays in FAULT until RESET; Run is ignored.
- Latency with zero-wait memory (MemReady=1 on the first request cycle): non-memory instruction 3 cycles, memory instruction 4 cycles. Each wait cycle adds 1.
- MemReady outside FETCH/MEMACC is ignored.
- IR and OPCODE are stable from DECODE through COMMIT; the control unit reads them combinationally.

Test Plan:
- Reset then Run=1, MemReady tied 1, Instr=16'h1000 (AADD, MemAccess=0): states 1,2,4,1 repeating; WriteEn and PCInc pulse every 3rd cycle; InstrCount=3 after 9 cycles.
- LOAD with MemAccess=1, MemWriteCU=0, MemReady low 2 cycles in MEMACC: MemReq high 3 cycles with FetchSel=0, MemWE=0; WriteEn pulses once at cycle 6 after FETCH entry.
- JIMM with JumpCU=1: COMMIT gives WriteEn=1, PCInc=0; next FETCH follows.
- Instr=16'hF800 (HALT_OP): after DECODE, State=0 and Halted=1, no WriteEn pulse, InstrCount unchanged; Run re-pulse clears Halted.
- MemReady held 0 in FETCH, WAIT_LIMIT=15: Fault=1 and State=5 after 16 request cycles; stays there despite MemReady=1; RESET returns to IDLE with Fault=0.
- RESET asserted mid-MEMACC of STOR: outputs zero immediately; no WriteEn, InstrCount=0. Also preset InstrCount near 16'hFFFF and check wrap to 0.

Source files
------------

// File: rtl/frankie_cycle_sequencer.sv
// Multicycle fetch/decode/memory/commit sequencer. It owns the shared memory port and the IR, and it strobes commits.
// Latency with zero-wait memory is 3 cycles (4 for a memory access), plus one cycle per MemReady stall; a stalled request faults after WAIT_LIMIT waits.
module frankie_cycle_sequencer #(
  parameter int         WAIT_LIMIT = 15,
  parameter logic [4:0] HALT_OP    = 5'b11111,
  parameter int         IR_WIDTH   = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                Run,
  input  logic [IR_WIDTH-1:0] Instr,
  input  logic                MemReady,
  input  logic                MemAccess,
  input  logic                MemWriteCU,
  input  logic                JumpCU,
  output logic [4:0]          OPCODE,
  output logic                flagbit,
  output logic                IRWrite,
  output logic                MemReq,
  output logic                FetchSel,
  output logic                MemWE,
  output logic                WriteEn,
  output logic                PCInc,
  output logic                Halted,
  output logic                Fault,
  output logic [15:0]         InstrCount,
  output logic [2:0]          State
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEMACC = 3'd3,
    S_COMMIT = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT);

  state_t              state;
  logic [IR_WIDTH-1:0] ir;
  logic [7:0]          wait_cnt;
  logic [15:0]         instr_count;

  // Operand bits are consumed by the datapath outside this block.
  logic unused_operand;
  assign unused_operand = ^ir[IR_WIDTH-7:0];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_IDLE;
      ir          <= '0;
      wait_cnt    <= '0;
      instr_count <= '0;
      Halted      <= 1'b0;
      Fault       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (Run) begin
            state  <= S_FETCH;
            Halted <= 1'b0;
          end
        end
        S_FETCH: begin
          if (MemReady) begin
            ir       <= Instr;
            wait_cnt <= '0;
            state    <= S_DECODE;
          end else if (wait_cnt == WAIT_MAX) begin
            state <= S_FAULT;
            Fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          if (OPCODE == HALT_OP) begin
            state  <= S_IDLE;
            Halted <= 1'b1;
          end else if (MemAccess) begin
            state <= S_MEMACC;
          end else begin
            state <= S_COMMIT;
          end
        end
        S_MEMACC: begin
          if (MemReady) begin
            wait_cnt <= '0;
            state    <= S_COMMIT;
          end else if (wait_cnt == WAIT_MAX) begin
            state <= S_FAULT;
            Fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_COMMIT: begin
          instr_count <= instr_count + 16'd1;
          state       <= Run ? S_FETCH : S_IDLE;
        end
        S_FAULT: begin
          Fault <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign OPCODE     = ir[IR_WIDTH-1 -: 5];
  assign flagbit    = ir[IR_WIDTH-6];
  assign InstrCount = instr_count;
  assign State      = state;

  // IRWrite is the only strobe that also looks at MemReady.
  assign IRWrite  = (state == S_FETCH) && MemReady;
  assign MemReq   = (state == S_FETCH) || (state == S_MEMACC);
  assign FetchSel = (state == S_FETCH);
  assign MemWE    = (state == S_MEMACC) && MemWriteCU;
  assign WriteEn  = (state == S_COMMIT);
  assign PCInc    = (state == S_COMMIT) && !JumpCU;

endmodule

// File: tb/tb_frankie_cycle_sequencer.sv
// Randomized bench for frankie_cycle_sequencer: a schedule-driven memory/control model feeds a scoreboard checked by a monitor.
module tb_frankie_cycle_sequencer;

  localparam logic [4:0] HALT = 5'b11111;

  logic        CLK;
  logic        RESET, Run, MemReady, MemAccess, MemWriteCU, JumpCU;
  logic [15:0] Instr;
  logic [4:0]  OPCODE;
  logic        flagbit, IRWrite, MemReq, FetchSel, MemWE, WriteEn, PCInc, Halted, Fault;
  logic [15:0] InstrCount;
  logic [2:0]  State;

  frankie_cycle_sequencer dut (
    .CLK(CLK), .RESET(RESET), .Run(Run), .Instr(Instr), .MemReady(MemReady),
    .MemAccess(MemAccess), .MemWriteCU(MemWriteCU), .JumpCU(JumpCU),
    .OPCODE(OPCODE), .flagbit(flagbit), .IRWrite(IRWrite), .MemReq(MemReq),
    .FetchSel(FetchSel), .MemWE(MemWE), .WriteEn(WriteEn), .PCInc(PCInc),
    .Halted(Halted), .Fault(Fault), .InstrCount(InstrCount), .State(State)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    logic        pcinc;
    logic [15:0] cnt;
    logic [4:0]  op;
    logic        flag;
  } commit_t;

  typedef struct {
    int   cyc;
    logic wr;
  } macc_t;

  commit_t     cq[$];
  macc_t       mq[$];
  int          iq[$];
  commit_t     ce;
  macc_t       me;
  int          ic;
  int          cyc, checks, errors;
  logic [15:0] model_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Monitor: pops an expectation whenever the DUT presents a fetch, data access or commit.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (IRWrite) begin
        if (iq.size() == 0) begin
          checks++; errors++;
          $display("FAIL fetch_unexpected: IRWrite at cycle %0d, expected none", cyc);
        end else begin
          ic = iq.pop_front();
          chk("fetch_cycle", 32'(cyc), 32'(ic));
          chk("fetch_state", 32'(State), 32'(3'd1));
          chk("fetch_sel", 32'(FetchSel), 32'(1'b1));
        end
      end
      if (MemReq && !FetchSel && MemReady) begin
        if (mq.size() == 0) begin
          checks++; errors++;
          $display("FAIL macc_unexpected: data access at cycle %0d, expected none", cyc);
        end else begin
          me = mq.pop_front();
          chk("macc_cycle", 32'(cyc), 32'(me.cyc));
          chk("macc_we", 32'(MemWE), 32'(me.wr));
        end
      end
      if (WriteEn) begin
        if (cq.size() == 0) begin
          checks++; errors++;
          $display("FAIL commit_unexpected: WriteEn at cycle %0d, expected none", cyc);
        end else begin
          ce = cq.pop_front();
          chk("commit_cycle", 32'(cyc), 32'(ce.cyc));
          chk("commit_pcinc", 32'(PCInc), 32'(ce.pcinc));
          chk("commit_count", 32'(InstrCount), 32'(ce.cnt));
          chk("commit_opcode", 32'(OPCODE), 32'(ce.op));
          chk("commit_flag", 32'(flagbit), 32'(ce.flag));
          chk("commit_state", 32'(State), 32'(3'd4));
        end
      end
      if (PCInc) chk("pcinc_gated", 32'(WriteEn), 32'(1'b1));
    end
  end

  task automatic do_reset();
    RESET = 1'b1; Run = 1'b0; MemReady = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("queues_drained", 32'(cq.size() + mq.size() + iq.size()), 32'(0));
    cq.delete(); mq.delete(); iq.delete();
    RESET = 1'b0;
    cyc = 0;
    model_count = 16'd0;
  endtask

  function automatic logic [15:0] rnd_instr(input bit allow_halt);
    logic [4:0] op;
    op = 5'($urandom);
    if (op == HALT) op = 5'b00001;
    if (allow_halt && $urandom_range(0, 7) == 0) op = HALT;
    return {op, 11'($urandom)};
  endfunction

  // Drives one instruction from the cycle its FETCH begins; returns on the cycle the next FETCH begins.
  task automatic run_instr(input logic [15:0] ins, input bit mem, input bit wr, input bit jmp,
                           input int fw, input int mw, input bit stop, input int gap);
    int F, fr, D, M, C, last;
    bit halt;
    commit_t e;
    macc_t   m;
    halt = (ins[15:11] == HALT);
    F  = cyc;
    fr = F + fw;
    D  = fr + 1;
    M  = D + 1;
    C  = mem ? M + mw + 1 : D + 1;
    last = halt ? D + 1 : (stop ? C + gap : C);
    iq.push_back(fr);
    if (!halt) begin
      if (mem) begin
        m.cyc = M + mw; m.wr = wr;
        mq.push_back(m);
      end
      e.cyc = C; e.pcinc = !jmp; e.cnt = model_count; e.op = ins[15:11]; e.flag = ins[10];
      cq.push_back(e);
      model_count = model_count + 16'd1;
    end
    for (int c = F; c <= last; c++) begin
      if (halt && c == D + 1) begin
        chk("halt_state", 32'(State), 32'(3'd0));
        chk("halt_flag", 32'(Halted), 32'(1'b1));
        chk("halt_count", 32'(InstrCount), 32'(model_count));
      end
      Instr      = (c == fr) ? ins : 16'($urandom);
      MemAccess  = (c <= fr) ? 1'($urandom) : mem;
      MemWriteCU = (c <= fr) ? 1'($urandom) : wr;
      JumpCU     = (c <= fr) ? 1'($urandom) : jmp;
      if (c < fr)                                  MemReady = 1'b0;
      else if (c == fr)                            MemReady = 1'b1;
      else if (mem && !halt && c >= M && c < C)    MemReady = (c == M + mw);
      else                                         MemReady = 1'($urandom);
      Run = !(stop && !halt && c < C + gap);
      step();
    end
    if (halt) begin
      chk("halt_cleared", 32'(Halted), 32'(1'b0));
      chk("halt_refetch", 32'(State), 32'(3'd1));
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; model_count = 16'd0;
    RESET = 1'b1; Run = 1'b0; MemReady = 1'b0; Instr = '0;
    MemAccess = 1'b0; MemWriteCU = 1'b0; JumpCU = 1'b0;
    do_reset();
    chk("reset_state", 32'(State), 32'(3'd0));
    chk("reset_count", 32'(InstrCount), 32'(16'd0));
    chk("reset_flags", 32'({Halted, Fault, OPCODE, flagbit}), 32'(0));
    chk("reset_strobes", 32'({IRWrite, MemReq, FetchSel, MemWE, WriteEn, PCInc}), 32'(0));

    // Back-to-back zero-wait AADD, then LOAD with two wait states, JIMM, HALT and WAIT_LIMIT boundaries.
    Run = 1'b1;
    step();
    repeat (3) run_instr(16'h1000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1);
    chk("count_after_aadd", 32'(InstrCount), 32'(16'd3));
    run_instr(16'h2400, 1'b1, 1'b0, 1'b0, 0, 2, 1'b0, 1);
    run_instr(16'h3000, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1);
    run_instr(16'hF800, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1);
    run_instr(16'h1800, 1'b1, 1'b1, 1'b0, 15, 15, 1'b0, 1);
    run_instr(16'h1000, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1, 2);

    for (int i = 0; i < 80; i++) begin
      run_instr(rnd_instr(1'b1), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0), $urandom_range(1, 3));
    end
    chk("count_after_random", 32'(InstrCount), 32'(model_count));

    // Fetch timeout: 16 request cycles then FAULT, which ignores MemReady/Run until RESET.
    MemReady = 1'b0;
    do_reset();
    Run = 1'b1;
    step();
    repeat (15) step();
    chk("timeout_last_fetch", 32'(State), 32'(3'd1));
    chk("timeout_last_req", 32'(MemReq), 32'(1'b1));
    step();
    chk("fault_state", 32'(State), 32'(3'd5));
    chk("fault_flag", 32'(Fault), 32'(1'b1));
    chk("fault_noreq", 32'(MemReq), 32'(1'b0));
    MemReady = 1'b1;
    repeat (3) step();
    chk("fault_sticky", 32'(State), 32'(3'd5));
    chk("fault_sticky_flag", 32'(Fault), 32'(1'b1));
    #2 RESET = 1'b1;
    #1;
    chk("fault_reset_state", 32'(State), 32'(3'd0));
    chk("fault_reset_flag", 32'(Fault), 32'(1'b0));

    // Reset in the middle of a STOR data access abandons it.
    do_reset();
    Run = 1'b1; Instr = 16'h1800; MemAccess = 1'b1; MemWriteCU = 1'b1; JumpCU = 1'b0;
    step();
    iq.push_back(1);
    MemReady = 1'b1;
    step();
    MemReady = 1'b0;
    step();
    chk("stor_req", 32'({MemReq, FetchSel, MemWE}), 32'(3'b101));
    step();
    #2 RESET = 1'b1;
    #1;
    chk("midreset_state", 32'(State), 32'(3'd0));
    chk("midreset_strobes", 32'({IRWrite, MemReq, FetchSel, MemWE, WriteEn, PCInc}), 32'(0));
    chk("midreset_count", 32'(InstrCount), 32'(16'd0));

    // Counter wrap from a preset near the top.
    do_reset();
    force dut.instr_count = 16'hFFFE;
    step();
    release dut.instr_count;
    model_count = 16'hFFFE;
    chk("preset_count", 32'(InstrCount), 32'(16'hFFFE));
    Run = 1'b1;
    step();
    repeat (3) run_instr(rnd_instr(1'b0), 1'($urandom), 1'($urandom), 1'($urandom),
                         $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1);
    chk("wrap_count", 32'(InstrCount), 32'(16'd1));

    MemReady = 1'b0;
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
